// File: rtl/probe_tx_arb_pkg.sv
// Shared types and constants for the probe/datapath transmit arbiter.
// Holds the FSM encoding, the framing ctrl value for body words and the counter width.
package probe_tx_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  localparam int CTRL_BODY = 0;
  localparam int PKT_CNT_W = 16;

  typedef enum logic {
    PH_HDR  = 1'b0,
    PH_BODY = 1'b1
  } phase_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/probe_tx_arb_if.sv
// Word-stream port (data/ctrl/wr with rdy back-pressure and packet-ready req).
// Master drives the word and req; slave returns rdy.
interface probe_tx_arb_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;
  logic                  req;

  modport master (output data, ctrl, wr, req, input rdy);
  modport slave  (input data, ctrl, wr, req, output rdy);
endinterface

// File: rtl/probe_tx_arb_pkt_boundary.sv
// HDR/BODY framing tracker on the granted write stream; eop pulses combinationally with the EOP write.
// No storage beyond the phase flop; it never back-pressures.
module pkt_boundary
  import probe_tx_arb_pkg::*;
#(
  parameter int CTRL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [CTRL_WIDTH-1:0] ctrl,
  output logic                  eop
);

  phase_e phase_q, phase_d;
  logic   is_body;

  always_comb begin
    is_body = (ctrl == CTRL_WIDTH'(CTRL_BODY));
    phase_d = phase_q;
    eop     = 1'b0;
    if (wr) begin
      if (is_body) begin
        phase_d = PH_BODY;
      end else if (phase_q == PH_BODY) begin
        phase_d = PH_HDR;
        eop     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase_q <= PH_HDR;
    else        phase_q <= phase_d;
  end

endmodule

// File: rtl/probe_tx_arb.sv
// Packet-granular 2:1 arbiter (probe priority, burst-limited) into the MAC tx port; 1-cycle registered output.
// Granted input's rdy follows out_rdy combinationally; the other input and IDLE see rdy=0.
module probe_tx_arb
  import probe_tx_arb_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_PROBE_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arb_en,
  probe_tx_arb_if.slave        in0,
  probe_tx_arb_if.slave        in1,
  probe_tx_arb_if.master       out,
  output logic [1:0]           grant,
  output logic [PKT_CNT_W-1:0] data_pkt_cnt,
  output logic [PKT_CNT_W-1:0] probe_pkt_cnt
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_PROBE_BURST);

  logic [1:0]            state_q, state_d;
  logic [7:0]            burst_cnt_q, burst_cnt_d;
  logic [PKT_CNT_W-1:0]  data_pkt_cnt_q, data_pkt_cnt_d;
  logic [PKT_CNT_W-1:0]  probe_pkt_cnt_q, probe_pkt_cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic                  out_wr_q, out_wr_d;

  logic                  rdy0, rdy1, sel1, acc_wr, eop;
  logic [DATA_WIDTH-1:0] mux_data;
  logic [CTRL_WIDTH-1:0] mux_ctrl;

  assign rdy0     = (state_q == ST_GNT0) && out.rdy;
  assign rdy1     = (state_q == ST_GNT1) && out.rdy;
  assign sel1     = (state_q == ST_GNT1);
  // Writes against a low rdy are dropped here, so they never reach the tracker or output.
  assign acc_wr   = (in0.wr && rdy0) || (in1.wr && rdy1);
  assign mux_data = sel1 ? in1.data : in0.data;
  assign mux_ctrl = sel1 ? in1.ctrl : in0.ctrl;

  pkt_boundary #(.CTRL_WIDTH(CTRL_WIDTH)) u_bnd (
    .clk   (clk),
    .reset (reset),
    .wr    (acc_wr),
    .ctrl  (mux_ctrl),
    .eop   (eop)
  );

  always_comb begin
    state_d         = state_q;
    burst_cnt_d     = burst_cnt_q;
    data_pkt_cnt_d  = data_pkt_cnt_q;
    probe_pkt_cnt_d = probe_pkt_cnt_q;
    out_wr_d        = acc_wr;
    out_data_d      = acc_wr ? mux_data : out_data_q;
    out_ctrl_d      = acc_wr ? mux_ctrl : out_ctrl_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_en) begin
          if (in1.req && ((burst_cnt_q < BURST_MAX) || !in0.req)) begin
            state_d     = ST_GNT1;
            burst_cnt_d = sat_inc8(burst_cnt_q);
          end else if (in0.req) begin
            state_d     = ST_GNT0;
            burst_cnt_d = '0;
          end
        end
      end
      ST_GNT0: begin
        if (eop) begin
          state_d        = ST_IDLE;
          data_pkt_cnt_d = data_pkt_cnt_q + PKT_CNT_W'(1);
        end
      end
      ST_GNT1: begin
        if (eop) begin
          state_d         = ST_IDLE;
          probe_pkt_cnt_d = probe_pkt_cnt_q + PKT_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      burst_cnt_q     <= '0;
      data_pkt_cnt_q  <= '0;
      probe_pkt_cnt_q <= '0;
      out_data_q      <= '0;
      out_ctrl_q      <= '0;
      out_wr_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      burst_cnt_q     <= burst_cnt_d;
      data_pkt_cnt_q  <= data_pkt_cnt_d;
      probe_pkt_cnt_q <= probe_pkt_cnt_d;
      out_data_q      <= out_data_d;
      out_ctrl_q      <= out_ctrl_d;
      out_wr_q        <= out_wr_d;
    end
  end

  assign in0.rdy       = rdy0;
  assign in1.rdy       = rdy1;
  assign out.data      = out_data_q;
  assign out.ctrl      = out_ctrl_q;
  assign out.wr        = out_wr_q;
  // The MAC port has no packet-ready request of its own.
  assign out.req       = 1'b0;
  assign grant         = {state_q == ST_GNT1, state_q == ST_GNT0};
  assign data_pkt_cnt  = data_pkt_cnt_q;
  assign probe_pkt_cnt = probe_pkt_cnt_q;

endmodule
